id_match_logger: RTL and testbench

//  Downstream consumer of the identifier detector. Runs on the same 1-char-per-clk stream and

---
 rtl/id_match_logger_if.sv | 24 ++
 rtl/id_match_logger.sv | 161 ++++++++++++++++
 tb/tb_id_match_logger.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_match_logger_if.sv
// Record read-out bus of id_match_logger: FWFT head valid/ready with {end_pos, len} payload.
interface id_match_logger_if #(
  parameter int POS_W = 16,
  parameter int LEN_W = 6
);
  logic             rec_valid;
  logic             rec_ready;
  logic [POS_W-1:0] rec_end_pos;
  logic [LEN_W-1:0] rec_len;

  modport master (
    output rec_valid,
    output rec_end_pos,
    output rec_len,
    input  rec_ready
  );

  modport slave (
    input  rec_valid,
    input  rec_end_pos,
    input  rec_len,
    output rec_ready
  );
endinterface

// File: rtl/id_match_logger.sv
// Tracks identifier run length and stream position; each detector match logs {end_pos, len}
// into a first-word-fall-through FIFO. Define ID_LOG_DROP_CNT_EN to add the o_drop_cnt output.
module id_match_logger #(
  parameter int DEPTH = 8,
  parameter int POS_W = 16,
  parameter int LEN_W = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             i_char,
  input  logic                   i_match,
  input  logic                   i_clr_ovf,
  id_match_logger_if.master      rec,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_ovf
`ifdef ID_LOG_DROP_CNT_EN
  ,
  output logic [7:0]             o_drop_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [LEN_W-1:0] LEN_MAX  = '1;
  localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);

  logic [POS_W-1:0] r_pos;
  logic [LEN_W-1:0] r_run_len;
  logic             r_in_id;
  logic             w_is_letter;
  logic             w_is_digit;
  logic [LEN_W-1:0] w_run_inc;
  logic [LEN_W-1:0] w_run_len_next;
  logic             w_in_id_next;

  assign w_is_letter = (i_char >= 8'h41) && (i_char <= 8'h7A);
  assign w_is_digit  = (i_char >= 8'h30) && (i_char <= 8'h39);
  assign w_run_inc   = (r_run_len == LEN_MAX) ? r_run_len : r_run_len + LEN_W'(1);

  // Digits extend an identifier but never start one.
  always_comb begin
    w_run_len_next = '0;
    w_in_id_next   = 1'b0;
    if (w_is_letter) begin
      w_run_len_next = r_in_id ? w_run_inc : LEN_W'(1);
      w_in_id_next   = 1'b1;
    end else if (w_is_digit) begin
      w_run_len_next = r_in_id ? w_run_inc : '0;
      w_in_id_next   = r_in_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos     <= '0;
      r_run_len <= '0;
      r_in_id   <= 1'b0;
    end else begin
      r_pos     <= r_pos + POS_W'(1);
      r_run_len <= w_run_len_next;
      r_in_id   <= w_in_id_next;
    end
  end

  logic [POS_W-1:0] r_mem_pos [DEPTH];
  logic [LEN_W-1:0] r_mem_len [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    w_rd_ptr_next;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  logic [POS_W-1:0] r_rec_pos;
  logic [LEN_W-1:0] r_rec_len;
  logic [POS_W-1:0] w_head_pos;
  logic [LEN_W-1:0] w_head_len;
  logic [POS_W-1:0] w_new_pos;
  logic             w_valid;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             r_ovf;

  // match arrives one cycle late, so the registered tracker state describes the matched char.
  assign w_new_pos     = r_pos - POS_W'(1);
  assign w_valid       = (r_count != '0);
  assign w_full        = (r_count == CNT_FULL);
  assign w_pop         = w_valid & rec.rec_ready;
  assign w_push        = i_match & (~w_full | w_pop);
  assign w_drop        = i_match & w_full & ~w_pop;
  assign w_rd_ptr_next = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
  assign w_count_next  = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pos[r_wr_ptr] <= w_new_pos;
      r_mem_len[r_wr_ptr] <= r_run_len;
    end
  end

  // Head register is loaded with whatever sits at the read pointer after this edge; a record
  // written into that very slot this cycle is forwarded directly.
  always_comb begin
    w_head_pos = r_rec_pos;
    w_head_len = r_rec_len;
    if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
      w_head_pos = w_new_pos;
      w_head_len = r_run_len;
    end else if (w_count_next != '0) begin
      w_head_pos = r_mem_pos[w_rd_ptr_next];
      w_head_len = r_mem_len[w_rd_ptr_next];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rec_pos <= '0;
      r_rec_len <= '0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr  <= w_rd_ptr_next;
      r_count   <= w_count_next;
      r_rec_pos <= w_head_pos;
      r_rec_len <= w_head_len;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (i_clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef ID_LOG_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (i_clr_ovf) begin
      r_drop_cnt <= '0;
    end
  end

  assign o_drop_cnt = r_drop_cnt;
`endif

  assign rec.rec_valid   = w_valid;
  assign rec.rec_end_pos = r_rec_pos;
  assign rec.rec_len     = r_rec_len;
  assign o_count         = r_count;
  assign o_ovf           = r_ovf;
endmodule

// File: tb/tb_id_match_logger.sv
// Bench for id_match_logger: directed scenarios with literal expectations plus a randomized
// stream, all checked every cycle against a queue-based model of the identifier/FIFO rules.
module tb_id_match_logger;
  localparam int DEPTH    = 8;
  localparam int POS_W    = 8;
  localparam int LEN_W    = 6;
  localparam int POS_MASK = (1 << POS_W) - 1;
  localparam int LEN_MAX  = (1 << LEN_W) - 1;
  localparam int HIST_N   = 8192;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [7:0]             ch = 8'h00;
  logic                   match = 1'b0;
  logic                   clr_ovf = 1'b0;
  logic [$clog2(DEPTH):0] count;
  logic                   ovf;
`ifdef ID_LOG_DROP_CNT_EN
  logic [7:0]             drop_cnt;
`endif

  id_match_logger_if #(.POS_W(POS_W), .LEN_W(LEN_W)) rec_if ();

  id_match_logger #(.DEPTH(DEPTH), .POS_W(POS_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_char    (ch),
    .i_match   (match),
    .i_clr_ovf (clr_ovf),
    .rec       (rec_if),
    .o_count   (count),
    .o_ovf     (ovf)
`ifdef ID_LOG_DROP_CNT_EN
    ,
    .o_drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: char history since reset plus a queue of pending records.
  logic [7:0] hist [0:HIST_N-1];
  int  idx = 0;
  int  q_pos[$];
  int  q_len[$];
  bit  m_ovf = 1'b0;
  int  m_n;
  bit  m_pop;
  bit  m_drop_now;
`ifdef ID_LOG_DROP_CNT_EN
  int  m_drop = 0;
`endif

  function automatic bit is_letter(logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h7A);
  endfunction

  function automatic bit is_digit(logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Length of the identifier ending at char 'last': from the earliest letter of the
  // contiguous alphanumeric run ending there, saturated.
  function automatic int id_len(int last);
    int first;
    first = -1;
    for (int k = last; k >= 0; k--) begin
      if (!(is_letter(hist[k]) || is_digit(hist[k]))) break;
      if (is_letter(hist[k])) first = k;
    end
    if (first < 0) return 0;
    return (last - first + 1 > LEN_MAX) ? LEN_MAX : (last - first + 1);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      idx = 0;
      q_pos.delete();
      q_len.delete();
      m_ovf = 1'b0;
`ifdef ID_LOG_DROP_CNT_EN
      m_drop = 0;
`endif
    end else begin
      m_n = q_pos.size();
      m_pop = (m_n > 0) && (rec_if.rec_ready === 1'b1);
      m_drop_now = 1'b0;
      if (m_pop) begin
        void'(q_pos.pop_front());
        void'(q_len.pop_front());
      end
      if (match) begin
        if (m_n < DEPTH || m_pop) begin
          q_pos.push_back((idx - 1) & POS_MASK);
          q_len.push_back(id_len(idx - 1));
        end else begin
          m_drop_now = 1'b1;
        end
      end
      if (m_drop_now) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
`ifdef ID_LOG_DROP_CNT_EN
      if (m_drop_now) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      else if (clr_ovf) m_drop = 0;
`endif
      if (idx < HIST_N) hist[idx] = ch;
      idx++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("count", 32'(count), 32'(q_pos.size()));
      chk("rec_valid", 32'(rec_if.rec_valid), 32'(q_pos.size() > 0));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      if (q_pos.size() > 0) begin
        chk("rec_end_pos", 32'(rec_if.rec_end_pos), 32'(q_pos[0]));
        chk("rec_len", 32'(rec_if.rec_len), 32'(q_len[0]));
      end
`ifdef ID_LOG_DROP_CNT_EN
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
    end
  end

  task automatic step(input logic [7:0] c, input logic m, input logic rdy, input logic clr);
    ch = c;
    match = m;
    rec_if.rec_ready = rdy;
    clr_ovf = clr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    match = 1'b0;
    clr_ovf = 1'b0;
    rec_if.rec_ready = 1'b0;
    ch = 8'h20;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int pct;
    int sel;
    rec_if.rec_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(rec_if.rec_valid), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_end_pos", 32'(rec_if.rec_end_pos), 32'd0);
    chk("rst_len", 32'(rec_if.rec_len), 32'd0);
    rst_n = 1'b1;

    // "ab1 " from pos 0, match one cycle after '1'
    step("a", 1'b0, 1'b1, 1'b0);
    step("b", 1'b0, 1'b1, 1'b0);
    step("1", 1'b0, 1'b1, 1'b0);
    step(" ", 1'b1, 1'b1, 1'b0);
    chk("ab1_valid", 32'(rec_if.rec_valid), 32'd1);
    chk("ab1_end_pos", 32'(rec_if.rec_end_pos), 32'd2);
    chk("ab1_len", 32'(rec_if.rec_len), 32'd3);
    step(" ", 1'b0, 1'b1, 1'b0);
    chk("ab1_drained", 32'(count), 32'd0);

    // "x12" with consumer stalled
    do_reset();
    step("x", 1'b0, 1'b0, 1'b0);
    step("1", 1'b0, 1'b0, 1'b0);
    step("2", 1'b1, 1'b0, 1'b0);
    step(" ", 1'b1, 1'b0, 1'b0);
    step(" ", 1'b0, 1'b0, 1'b0);
    step(" ", 1'b0, 1'b0, 1'b0);
    chk("x12_count", 32'(count), 32'd2);
    chk("x12_hold_pos", 32'(rec_if.rec_end_pos), 32'd1);
    chk("x12_hold_len", 32'(rec_if.rec_len), 32'd2);
    step(" ", 1'b0, 1'b1, 1'b0);
    chk("x12_second_pos", 32'(rec_if.rec_end_pos), 32'd2);
    chk("x12_second_len", 32'(rec_if.rec_len), 32'd3);
    step(" ", 1'b0, 1'b1, 1'b0);
    chk("x12_empty", 32'(rec_if.rec_valid), 32'd0);

    // fill, push+pop on full, overflow, clear, clear-vs-drop
    do_reset();
    for (int i = 0; i < DEPTH; i++) step("a", 1'b1, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'(DEPTH));
    step("a", 1'b1, 1'b1, 1'b0);
    chk("full_pushpop_count", 32'(count), 32'(DEPTH));
    chk("full_pushpop_ovf", 32'(ovf), 32'd0);
    step("a", 1'b1, 1'b0, 1'b0);
    chk("drop_count", 32'(count), 32'(DEPTH));
    chk("drop_ovf", 32'(ovf), 32'd1);
`ifdef ID_LOG_DROP_CNT_EN
    chk("drop_cnt1", 32'(drop_cnt), 32'd1);
`endif
    step(" ", 1'b0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(ovf), 32'd0);
    step("a", 1'b1, 1'b0, 1'b1);
    chk("set_wins_ovf", 32'(ovf), 32'd1);
`ifdef ID_LOG_DROP_CNT_EN
    chk("set_wins_cnt", 32'(drop_cnt), 32'd1);
`endif
    // asynchronous reset with the FIFO full
    #2 rst_n = 1'b0;
    #1;
    chk("areset_count", 32'(count), 32'd0);
    chk("areset_valid", 32'(rec_if.rec_valid), 32'd0);
    chk("areset_ovf", 32'(ovf), 32'd0);
    match = 1'b0;
    clr_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 70-letter identifier then '5': length saturates
    do_reset();
    for (int i = 0; i < 70; i++) step("a", 1'b0, 1'b1, 1'b0);
    step("5", 1'b0, 1'b1, 1'b0);
    step(" ", 1'b1, 1'b1, 1'b0);
    chk("sat_len", 32'(rec_if.rec_len), 32'(LEN_MAX));
    chk("sat_end_pos", 32'(rec_if.rec_end_pos), 32'd70);
    step(" ", 1'b0, 1'b1, 1'b0);

    // position wrap
    do_reset();
    for (int i = 0; i <= POS_MASK; i++) step("z", 1'b0, 1'b0, 1'b0);
    step("z", 1'b1, 1'b0, 1'b0);
    step("z", 1'b1, 1'b0, 1'b0);
    chk("wrap_count", 32'(count), 32'd2);
    chk("wrap_pos_max", 32'(rec_if.rec_end_pos), 32'(POS_MASK));
    step("z", 1'b0, 1'b1, 1'b0);
    chk("wrap_pos_zero", 32'(rec_if.rec_end_pos), 32'd0);
    chk("wrap_len", 32'(rec_if.rec_len), 32'(LEN_MAX));
    step(" ", 1'b0, 1'b1, 1'b0);

    // randomized stream with alternating fill/drain phases
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      sel = int'($urandom_range(0, 9));
      if (sel < 5)       ch = 8'($urandom_range(8'h41, 8'h7A));
      else if (sel < 7)  ch = 8'($urandom_range(8'h30, 8'h39));
      else if (sel < 8)  ch = 8'h20;
      else               ch = 8'($urandom_range(0, 255));
      pct = ((i % 600) < 300) ? 20 : 80;
      match = ($urandom_range(0, 99) < 30);
      rec_if.rec_ready = (int'($urandom_range(0, 99)) < pct);
      clr_ovf = ($urandom_range(0, 99) < 3);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
